// File: rtl/iq_link_pkg.sv
// Shared types for the 2x-rate I/Q time-multiplexed link.
// Used by both the interleaver and the deinterleaver.
package iq_link_pkg;

  localparam int unsigned IqDataW = 16;

  typedef logic signed [IqDataW-1:0] sample_t;

  typedef enum logic [0:0] {
    HUNT,
    GOT_RE
  } iq_rx_state_e;

endpackage

// File: rtl/iq_lock_mon.sv
// Pair-alignment lock tracker and saturating protocol-error counter.
module iq_lock_mon #(
  parameter int unsigned LOCK_PAIRS = 4,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pair_ok_i,
  input  logic                 err_i,
  output logic                 locked_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned LockW = $clog2(LOCK_PAIRS + 1);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_PAIRS);

  logic [LockW-1:0]     cnt_d, cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic                 locked_q;

  always_comb begin
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    // An error and a completed pair are mutually exclusive, so error wins trivially.
    if (err_i) begin
      cnt_d = '0;
    end else if (pair_ok_i && (cnt_q != LockMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (err_i && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= (cnt_d == LockMax);
    end
  end

  assign locked_o  = locked_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/iq_deinterleave.sv
// Rebuilds parallel re/im pairs from the single-lane 2x-rate I/Q stream,
// tracking alignment, lock and protocol errors.
module iq_deinterleave
  import iq_link_pkg::*;
#(
  parameter int unsigned DATA_W     = IqDataW,
  parameter int unsigned LOCK_PAIRS = 4,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 re_p_im_i,
  input  logic                 valid_i,
  output logic [DATA_W-1:0]    data_re_o,
  output logic [DATA_W-1:0]    data_im_o,
  output logic                 valid_o,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  iq_rx_state_e      state_d, state_q;
  logic [DATA_W-1:0] re_hold_d, re_hold_q;
  logic [DATA_W-1:0] data_re_d, data_re_q;
  logic [DATA_W-1:0] data_im_d, data_im_q;
  logic              pair_evt, err_evt;
  logic              valid_q, err_q;

  always_comb begin
    state_d   = state_q;
    re_hold_d = re_hold_q;
    data_re_d = data_re_q;
    data_im_d = data_im_q;
    pair_evt  = 1'b0;
    err_evt   = 1'b0;
    if (valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (re_p_im_i) begin
            re_hold_d = data_i;
            state_d   = GOT_RE;
          end else if (locked_o) begin
            // Stray imaginary half only counts as misalignment once locked.
            err_evt = 1'b1;
          end
        end
        GOT_RE: begin
          if (!re_p_im_i) begin
            data_re_d = re_hold_q;
            data_im_d = data_i;
            pair_evt  = 1'b1;
            state_d   = HUNT;
          end else begin
            err_evt   = 1'b1;
            re_hold_d = data_i;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= HUNT;
      re_hold_q <= '0;
      data_re_q <= '0;
      data_im_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      re_hold_q <= re_hold_d;
      data_re_q <= data_re_d;
      data_im_q <= data_im_d;
      valid_q   <= pair_evt;
      err_q     <= err_evt;
    end
  end

  iq_lock_mon #(
    .LOCK_PAIRS(LOCK_PAIRS),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_lock_mon (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .pair_ok_i(pair_evt),
    .err_i    (err_evt),
    .locked_o (locked_o),
    .err_cnt_o(err_cnt_o)
  );

  assign data_re_o = data_re_q;
  assign data_im_o = data_im_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_iq_deinterleave.sv
// Directed bench for iq_deinterleave; a second instance with a 2-bit error counter
// shares the stimulus to exercise counter saturation.
module tb_iq_deinterleave;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] data_i = '0;
  logic        re_p_im_i = 1'b0;
  logic        valid_i = 1'b0;

  logic [15:0] data_re_o, data_im_o;
  logic        valid_o, locked_o, err_o;
  logic [7:0]  err_cnt_o;

  logic [15:0] s_data_re_o, s_data_im_o;
  logic        s_valid_o, s_locked_o, s_err_o;
  logic [1:0]  s_err_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  iq_deinterleave #(
    .DATA_W    (16),
    .LOCK_PAIRS(4),
    .ERR_CNT_W (8)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .data_i   (data_i),
    .re_p_im_i(re_p_im_i),
    .valid_i  (valid_i),
    .data_re_o(data_re_o),
    .data_im_o(data_im_o),
    .valid_o  (valid_o),
    .locked_o (locked_o),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o)
  );

  iq_deinterleave #(
    .DATA_W    (16),
    .LOCK_PAIRS(4),
    .ERR_CNT_W (2)
  ) dut_sat (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .data_i   (data_i),
    .re_p_im_i(re_p_im_i),
    .valid_i  (valid_i),
    .data_re_o(s_data_re_o),
    .data_im_o(s_data_im_o),
    .valid_o  (s_valid_o),
    .locked_o (s_locked_o),
    .err_o    (s_err_o),
    .err_cnt_o(s_err_cnt_o)
  );

  // Present one beat from a negedge, let the posedge take it, then look 1ns later.
  task automatic drive(input logic v, input logic re, input logic [15:0] d);
    @(negedge clk_i);
    valid_i   = v;
    re_p_im_i = re;
    data_i    = d;
    @(posedge clk_i);
    #1;
    valid_i   = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (data_re_o !== 16'h0) begin errors++; $display("FAIL reset_re got %h want 0000", data_re_o); end
    checks++; if (data_im_o !== 16'h0) begin errors++; $display("FAIL reset_im got %h want 0000", data_im_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
    checks++; if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", err_cnt_o); end
  endtask

  task automatic test_alternating();
    apply_reset();
    drive(1'b1, 1'b1, 16'h1234);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL alt_valid_re1 got %b want 0", valid_o); end
    drive(1'b1, 1'b0, 16'hFEDC);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL alt_valid_im1 got %b want 1", valid_o); end
    checks++; if (data_re_o !== 16'h1234 || data_im_o !== 16'hFEDC) begin
      errors++; $display("FAIL alt_pair1 got %h/%h want 1234/fedc", data_re_o, data_im_o); end
    drive(1'b1, 1'b1, 16'h0001);
    checks++; if (valid_o !== 1'b0 || data_re_o !== 16'h1234) begin
      errors++; $display("FAIL alt_hold valid=%b re=%h want 0/1234", valid_o, data_re_o); end
    drive(1'b1, 1'b0, 16'h8000);
    checks++; if (valid_o !== 1'b1 || data_re_o !== 16'h0001 || data_im_o !== 16'h8000) begin
      errors++; $display("FAIL alt_pair2 got %b %h/%h want 1 0001/8000", valid_o, data_re_o, data_im_o); end
    checks++; if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL alt_errcnt got %0d want 0", err_cnt_o); end
  endtask

  task automatic test_lock();
    logic [15:0] d;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      d = 16'(i);
      drive(1'b1, 1'b1, 16'h1000 + d);
      drive(1'b1, 1'b0, 16'h2000 + d);
      checks++; if (valid_o !== 1'b1 || locked_o !== (i >= 3)) begin
        errors++; $display("FAIL lock_pair%0d valid=%b locked=%b want 1/%b", i, valid_o, locked_o, (i >= 3)); end
    end
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (locked_o !== 1'b1 || err_o !== 1'b0) begin
      errors++; $display("FAIL lock_hold locked=%b err=%b want 1/0", locked_o, err_o); end
  endtask

  task automatic test_realign();
    // Entered locked from test_lock.
    drive(1'b1, 1'b1, 16'h0AAA);
    checks++; if (err_o !== 1'b0 || locked_o !== 1'b1) begin
      errors++; $display("FAIL realign_first err=%b locked=%b want 0/1", err_o, locked_o); end
    drive(1'b1, 1'b1, 16'h0BBB);
    checks++; if (err_o !== 1'b1 || locked_o !== 1'b0 || err_cnt_o !== 8'd1) begin
      errors++; $display("FAIL realign_err err=%b locked=%b cnt=%0d want 1/0/1", err_o, locked_o, err_cnt_o); end
    drive(1'b1, 1'b0, 16'h0CCC);
    checks++; if (valid_o !== 1'b1 || data_re_o !== 16'h0BBB || data_im_o !== 16'h0CCC || err_o !== 1'b0) begin
      errors++; $display("FAIL realign_pair got %b %h/%h err=%b want 1 0bbb/0ccc 0", valid_o, data_re_o, data_im_o, err_o); end
    // Relock (pair above is #1), then a stray im while locked is a misalignment error.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 16'h0111);
      drive(1'b1, 1'b0, 16'h0222);
    end
    checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", locked_o); end
    drive(1'b1, 1'b0, 16'h0333);
    checks++; if (err_o !== 1'b1 || locked_o !== 1'b0 || valid_o !== 1'b0 || err_cnt_o !== 8'd2) begin
      errors++; $display("FAIL misalign err=%b locked=%b valid=%b cnt=%0d want 1/0/0/2", err_o, locked_o, valid_o, err_cnt_o); end
  endtask

  task automatic test_unlocked_discard();
    apply_reset();
    drive(1'b1, 1'b0, 16'h5555);
    checks++; if (err_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL discard err=%b valid=%b want 0/0", err_o, valid_o); end
    drive(1'b1, 1'b1, 16'h1111);
    drive(1'b1, 1'b0, 16'h2222);
    checks++; if (valid_o !== 1'b1 || data_re_o !== 16'h1111 || data_im_o !== 16'h2222 || err_cnt_o !== 8'd0) begin
      errors++; $display("FAIL discard_pair got %b %h/%h cnt=%0d want 1 1111/2222 0", valid_o, data_re_o, data_im_o, err_cnt_o); end
  endtask

  task automatic test_idle_gap();
    apply_reset();
    drive(1'b1, 1'b1, 16'h7FFF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 16'hDEAD);
      checks++; if (valid_o !== 1'b0 || err_o !== 1'b0) begin
        errors++; $display("FAIL idle%0d valid=%b err=%b want 0/0", i, valid_o, err_o); end
    end
    drive(1'b1, 1'b0, 16'h8001);
    checks++; if (valid_o !== 1'b1 || data_re_o !== 16'h7FFF || data_im_o !== 16'h8001 || err_o !== 1'b0) begin
      errors++; $display("FAIL idle_pair got %b %h/%h err=%b want 1 7fff/8001 0", valid_o, data_re_o, data_im_o, err_o); end
    drive(1'b0, 1'b0, 16'h0);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL idle_strobe got %b want 0", valid_o); end
  endtask

  task automatic test_saturate_and_midpair_reset();
    apply_reset();
    drive(1'b1, 1'b1, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 16'h0010);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL sat_err%0d got %b want 1", i, err_o); end
    end
    checks++; if (err_cnt_o !== 8'd5) begin errors++; $display("FAIL errcnt5 got %0d want 5", err_cnt_o); end
    checks++; if (s_err_cnt_o !== 2'd3) begin errors++; $display("FAIL errcnt_sat got %0d want 3", s_err_cnt_o); end
    // Asynchronous reset mid-pair (FSM is waiting for an imaginary half).
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (err_cnt_o !== 8'd0 || err_o !== 1'b0 || valid_o !== 1'b0 || locked_o !== 1'b0 ||
                  data_re_o !== 16'h0 || data_im_o !== 16'h0 || s_err_cnt_o !== 2'd0) begin
      errors++; $display("FAIL async_reset cnt=%0d err=%b valid=%b lock=%b re=%h im=%h scnt=%0d want all 0",
                         err_cnt_o, err_o, valid_o, locked_o, data_re_o, data_im_o, s_err_cnt_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b1, 1'b0, 16'h3333);
    checks++; if (valid_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_im valid=%b err=%b want 0/0", valid_o, err_o); end
    drive(1'b1, 1'b1, 16'h4444);
    drive(1'b1, 1'b0, 16'h5555);
    checks++; if (valid_o !== 1'b1 || data_re_o !== 16'h4444 || data_im_o !== 16'h5555) begin
      errors++; $display("FAIL post_reset_pair got %b %h/%h want 1 4444/5555", valid_o, data_re_o, data_im_o); end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_lock();
    test_realign();
    test_unlocked_discard();
    test_idle_gap();
    test_saturate_and_midpair_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
